axi_master: RTL and testbench
=============================

AXI_MASTER -- requirements
Module: axi_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; the only supported value is 32.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port areset_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-005 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1), cmd_addr (in, ADDR_W) and cmd_len (in, 8): command channel; beats = cmd_len+1.
REQ-006 SHALL have ports wd_valid (in, 1), wd_ready (out, 1) and wd_data (in, DATA_W): write-data stream.
REQ-007 SHALL have ports rd_valid (out, 1), rd_data (out, DATA_W) and rd_last (out, 1): read-data stream, with no backpressure.
REQ-008 SHALL have ports done (out, 1), done_resp (out, 2) and done_err (out, 1): end-of-transaction report.
REQ-009 SHALL have AXI master ports:
- awaddr (out, ADDR_W), awlen (out, 8), awsize (out, 3), awburst (out, 2), awvalid (out, 1), awready (in, 1).
- wdata (out, DATA_W), wlast (out, 1), wvalid (out, 1), wready (in, 1).
- bresp (in, 2), bvalid (in, 1), bready (out, 1).
- araddr, arlen, arsize, arburst and arvalid (out, same widths as AW), arready (in, 1).
- rdata (in, DATA_W), rresp (in, 2), rlast (in, 1), rvalid (in, 1), rready (out, 1).

Function
REQ-010 SHALL implement FSM states IDLE, AW, W, B, AR and R.
REQ-011 SHALL assert cmd_ready only in IDLE.
REQ-012 SHALL, on cmd_valid&&cmd_ready, latch addr, len and write; the next state is AW if write=1, else AR.
REQ-013 SHALL drive awvalid=1 only in AW and arvalid=1 only in AR, with address/len held stable from the latched command until the handshake.
REQ-014 SHALL drive awsize=arsize=3'b010 and awburst=arburst=2'b01 (INCR) constantly.
REQ-015 SHALL move AW->W on awvalid&&awready, and AR->R on arvalid&&arready.
REQ-016 SHALL use an 8-bit beat counter that clears on entry to W or R and increments on each data handshake.
REQ-017 In W, SHALL drive (combinationally) wvalid=wd_valid, wd_ready=wready, wdata=wd_data and wlast=(beat_cnt==len); outside W, wvalid=wd_ready=wlast=0.
REQ-018 SHALL move W->B on wvalid&&wready&&wlast.
REQ-019 SHALL assert bready only in B; on bvalid the state goes to IDLE, and done pulses for 1 cycle with done_resp=bresp.
REQ-020 SHALL assert rready=1 throughout R.
REQ-021 In R, SHALL drive rd_valid=rvalid, rd_data=rdata and rd_last=rvalid&&(beat_cnt==len).
REQ-022 SHALL end a read burst on the beat where beat_cnt==len (counter-based); rlast SHALL NOT terminate the burst.
REQ-023 SHALL set done_err for that done pulse if the rlast value on any read beat differs from (beat_cnt==len).
REQ-024 SHALL report done_resp for reads as the numerically largest rresp seen in the burst (the accumulator clears on entry to R).
REQ-025 SHALL leave an idle AXI handshake (e.g. awready high outside AW) without effect.
REQ-026 SHALL give done a latency of 1 cycle after the final B or R handshake (registered pulse).
REQ-027 SHALL, with cmd_len=255, complete 256 beats; the beat counter SHALL NOT wrap before the last beat.
REQ-028 SHALL ignore cmd_valid outside IDLE; a command held across done is accepted the cycle after return to IDLE.

Reset
REQ-029 SHALL, on areset_n=0 (asynchronously), force state to IDLE and clear beat_cnt, the latched fields and the resp accumulator.
REQ-030 SHALL, during reset, drive all valid/ready/done/done_err outputs to 0 and all address/data/resp outputs to 0.
REQ-031 SHALL allow reset asserted mid-burst to abandon the burst with no done pulse; the first cycle after release has cmd_ready=1.

Verification
REQ-032 Single write, addr=0x0, len=0, data 0xA5A5A5A5, bresp=0 -> awvalid, then 1 beat with wlast=1, bready, done=1 with done_resp=0.
REQ-033 Read, addr=0x2, len=3, slave returns 0x10..0x13 with correct rlast -> 4 rd_valid beats, rd_last on 0x13 only, done=1, done_err=0.
REQ-034 Read, len=1, slave asserts rlast on beat 0 -> burst still takes 2 beats; done_err=1.
REQ-035 Write, len=3, wd_valid toggling every other cycle and wready stalled 2 cycles -> exactly 4 W handshakes, wlast on the 4th, in-order data.
REQ-036 Read, len=7, rresp = 0,0,2,0,... -> done_resp=2.
REQ-037 Reset at the 3rd write beat of len=7 -> all outputs 0 immediately; after release, IDLE with cmd_ready=1 and no done pulse.

Source files
------------

// File: rtl/axi_master.sv
// Purpose : turns one command (addr, len, write) into a single AXI4 INCR burst of 32-bit beats.
// Latency : cmd accepted in IDLE; done pulses 1 cycle after the final B or R handshake.
// Backpr. : cmd_ready only in IDLE; write data follows wready; read data has no backpressure (rready=1 in R).
//
// Ports:
//   aclk, areset_n                 clock, asynchronous active-low reset
//   cmd_*                          command in (beats = cmd_len+1)
//   wd_valid/wd_ready/wd_data      write-data stream in, passed through to W
//   rd_valid/rd_data/rd_last       read-data stream out, no backpressure
//   done/done_resp/done_err        one-cycle end-of-transaction report
//   aw*/w*/b*/ar*/r*               AXI master channels
// DATA_W must be 32: awsize/arsize are fixed at 4 bytes per beat.
module axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset_n,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  // write-data stream
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  // read-data stream
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  // completion report
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              done_err,
  // AXI write address
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI read address
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt;
  logic [1:0]        resp_acc;   // largest rresp seen so far in the read burst
  logic              err_acc;    // any rlast disagreement so far in the read burst

  logic       last_beat;
  logic       w_hs;
  logic       r_hs;
  logic [1:0] resp_max;
  logic       rlast_bad;

  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = (state == W) && wd_valid && wready;
  assign r_hs      = (state == R) && rvalid;             // rready is 1 throughout R
  assign resp_max  = (rresp > resp_acc) ? rresp : resp_acc;
  // The burst length is owned by the counter; rlast is only cross-checked.
  assign rlast_bad = (rlast != last_beat);

  // The write flag is not kept separately: it is encoded by the AW/AR branch taken.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      resp_acc  <= '0;
      err_acc   <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
      done_err  <= 1'b0;
    end else begin
      done      <= 1'b0;
      done_resp <= '0;
      done_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            state  <= cmd_write ? AW : AR;
          end
        end
        AW: begin
          if (awready) begin
            beat_cnt <= '0;
            state    <= W;
          end
        end
        W: begin
          if (w_hs) begin
            // Wraps only on the final beat of a 256-beat burst, after which it is unused.
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= B;
          end
        end
        B: begin
          if (bvalid) begin
            done      <= 1'b1;
            done_resp <= bresp;
            state     <= IDLE;
          end
        end
        AR: begin
          if (arready) begin
            beat_cnt <= '0;
            resp_acc <= '0;
            err_acc  <= 1'b0;
            state    <= R;
          end
        end
        R: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            resp_acc <= resp_max;
            err_acc  <= err_acc | rlast_bad;
            if (last_beat) begin
              // Fold in the final beat directly rather than waiting for the accumulators.
              done      <= 1'b1;
              done_resp <= resp_max;
              done_err  <= err_acc | rlast_bad;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // State is already IDLE while reset is held, so cmd_ready is masked to keep it low then.
  assign cmd_ready = areset_n && (state == IDLE);

  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awvalid = (state == AW);

  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = (state == AR);

  assign wvalid   = (state == W) && wd_valid;
  assign wd_ready = (state == W) && wready;
  assign wdata    = (state == W) ? wd_data : '0;
  assign wlast    = (state == W) && last_beat;

  assign bready = (state == B);
  assign rready = (state == R);

  assign rd_valid = (state == R) && rvalid;
  assign rd_data  = (state == R) ? rdata : '0;
  assign rd_last  = rd_valid && last_beat;

endmodule

// File: tb/tb_axi_master.sv
// Purpose : randomized directed bench for axi_master with a transaction-level reference model.
// Latency : inputs change at the falling edge, outputs sampled 1 time unit later.
// Backpr. : the bench plays the AXI slave and the stream source, with random stalls.
module tb_axi_master;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic [1:0]  done_resp;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Transaction payloads: write data source and read slave responses per beat.
  logic [31:0] wq   [256];
  logic [31:0] rd_d [256];
  logic [1:0]  rd_r [256];
  logic        rd_l [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic scramble_cmd();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_len   = 8'($urandom);
  endtask

  task automatic noise();
    awready  = 1'($urandom);
    arready  = 1'($urandom);
    wready   = 1'($urandom);
    bvalid   = 1'($urandom);
    bresp    = 2'($urandom);
    rvalid   = 1'($urandom);
    rdata    = $urandom;
    rresp    = 2'($urandom);
    rlast    = 1'($urandom);
    wd_valid = 1'($urandom);
    wd_data  = $urandom;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_wd_ready"},  wd_ready, 0);
    chk({tag, "_rd_valid"},  rd_valid, 0);
    chk({tag, "_rd_data"},   rd_data, 0);
    chk({tag, "_rd_last"},   rd_last, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_done_resp"}, done_resp, 0);
    chk({tag, "_done_err"},  done_err, 0);
    chk({tag, "_awvalid"},   awvalid, 0);
    chk({tag, "_awaddr"},    awaddr, 0);
    chk({tag, "_awlen"},     awlen, 0);
    chk({tag, "_wvalid"},    wvalid, 0);
    chk({tag, "_wdata"},     wdata, 0);
    chk({tag, "_wlast"},     wlast, 0);
    chk({tag, "_bready"},    bready, 0);
    chk({tag, "_arvalid"},   arvalid, 0);
    chk({tag, "_araddr"},    araddr, 0);
    chk({tag, "_arlen"},     arlen, 0);
    chk({tag, "_rready"},    rready, 0);
  endtask

  // Present a command in IDLE; it is taken at the next rising edge.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input int len);
    @(negedge aclk);
    noise();
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len[7:0];
    #1;
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_rd_valid",  rd_valid, 0);
    chk("idle_wd_ready",  wd_ready, 0);
    chk("idle_done",      done, 0);
  endtask

  // mode 0: random wd_valid/wready; mode 1: wd_valid every other cycle, wready low for 2 cycles.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] resp, input int mode);
    int d, k, beat, c, hs_obs;
    issue_cmd(1'b1, addr, len);
    d = $urandom_range(0, 3);
    k = 0;
    do begin
      @(negedge aclk);
      scramble_cmd();
      awready = (k >= d); arready = 1'b1; wd_valid = 1'b1; wready = 1'b1;
      #1;
      chk("aw_awvalid", awvalid, 1);
      chk("aw_awaddr",  awaddr, addr);
      chk("aw_awlen",   awlen, len);
      chk("aw_awsize",  awsize, 3'b010);
      chk("aw_awburst", awburst, 2'b01);
      chk("aw_arvalid", arvalid, 0);
      chk("aw_wvalid",  wvalid, 0);
      k++;
    end while (k <= d);
    beat = 0; c = 0; hs_obs = 0;
    while (beat <= len) begin
      @(negedge aclk);
      scramble_cmd();
      if (mode == 1) begin
        wd_valid = (c % 2 == 0);
        wready   = (c >= 2);
      end else begin
        wd_valid = ($urandom % 4 != 0);
        wready   = ($urandom % 4 != 0);
      end
      wd_data = wd_valid ? wq[beat] : $urandom;
      #1;
      chk("w_wvalid",    wvalid, wd_valid);
      chk("w_wd_ready",  wd_ready, wready);
      chk("w_wlast",     wlast, (beat == len));
      chk("w_cmd_ready", cmd_ready, 0);
      if (wd_valid) chk("w_wdata", wdata, wq[beat]);
      if (wvalid && wd_ready) hs_obs++;
      if (wd_valid && wready) beat++;
      c++;
      if (c > 4000) begin
        chk("w_timeout", 0, 1);
        return;
      end
    end
    chk("w_handshakes", hs_obs, len + 1);
    d = $urandom_range(0, 3);
    k = 0;
    do begin
      @(negedge aclk);
      scramble_cmd();
      wd_valid = 1'($urandom); wready = 1'($urandom);
      bvalid = (k >= d);
      bresp  = (k >= d) ? resp : 2'($urandom);
      #1;
      chk("b_bready", bready, 1);
      chk("b_wvalid", wvalid, 0);
      chk("b_done",   done, 0);
      k++;
    end while (k <= d);
    @(negedge aclk);
    cmd_valid = 1'b0; bvalid = 1'($urandom); wd_valid = 1'b1; wready = 1'b1;
    #1;
    chk("wdone_done",      done, 1);
    chk("wdone_resp",      done_resp, resp);
    chk("wdone_err",       done_err, 0);
    chk("wdone_cmd_ready", cmd_ready, 1);
    chk("wdone_bready",    bready, 0);
    chk("wdone_wd_ready",  wd_ready, 0);
    @(negedge aclk);
    bvalid = 1'b0;
    #1;
    chk("wdone_pulse_end", done, 0);
  endtask

  // Read burst of len+1 beats using rd_d/rd_r/rd_l as the slave's answers.
  task automatic do_read(input logic [31:0] addr, input int len);
    int d, k, i, c;
    logic [1:0] exp_resp;
    logic       exp_err;
    exp_resp = 2'd0;
    exp_err  = 1'b0;
    for (int j = 0; j <= len; j++) begin
      if (rd_r[j] > exp_resp) exp_resp = rd_r[j];
      if (rd_l[j] != (j == len)) exp_err = 1'b1;
    end
    issue_cmd(1'b0, addr, len);
    d = $urandom_range(0, 3);
    k = 0;
    do begin
      @(negedge aclk);
      scramble_cmd();
      arready = (k >= d); awready = 1'b1; rvalid = 1'b1;
      #1;
      chk("ar_arvalid", arvalid, 1);
      chk("ar_araddr",  araddr, addr);
      chk("ar_arlen",   arlen, len);
      chk("ar_arsize",  arsize, 3'b010);
      chk("ar_arburst", arburst, 2'b01);
      chk("ar_awvalid", awvalid, 0);
      chk("ar_rd_valid", rd_valid, 0);
      k++;
    end while (k <= d);
    i = 0; c = 0;
    while (i <= len) begin
      @(negedge aclk);
      scramble_cmd();
      rvalid = ($urandom % 4 != 0);
      rdata  = rvalid ? rd_d[i] : $urandom;
      rresp  = rvalid ? rd_r[i] : 2'($urandom);
      rlast  = rvalid ? rd_l[i] : 1'($urandom);
      #1;
      chk("r_rready",   rready, 1);
      chk("r_rd_valid", rd_valid, rvalid);
      chk("r_done",     done, 0);
      if (rvalid) begin
        chk("r_rd_data", rd_data, rd_d[i]);
        chk("r_rd_last", rd_last, (i == len));
        i++;
      end
      c++;
      if (c > 4000) begin
        chk("r_timeout", 0, 1);
        return;
      end
    end
    @(negedge aclk);
    cmd_valid = 1'b0; rvalid = 1'($urandom); rlast = 1'b1;
    #1;
    chk("rdone_done",      done, 1);
    chk("rdone_resp",      done_resp, exp_resp);
    chk("rdone_err",       done_err, exp_err);
    chk("rdone_rd_valid",  rd_valid, 0);
    chk("rdone_rready",    rready, 0);
    chk("rdone_cmd_ready", cmd_ready, 1);
    @(negedge aclk);
    rvalid = 1'b0;
    #1;
    chk("rdone_pulse_end", done, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    areset_n = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    noise();
    #2 areset_n = 1'b0;

    // Reset state with busy-looking inputs.
    @(negedge aclk);
    noise(); cmd_valid = 1'b1;
    #1;
    chk_zero("reset");
    @(negedge aclk);
    areset_n = 1'b1; cmd_valid = 1'b0;
    #1;
    chk("post_reset_cmd_ready", cmd_ready, 1);

    // Single-beat write.
    wq[0] = 32'hA5A5_A5A5;
    do_write(32'h0, 0, 2'd0, 0);

    // Four-beat read with correct rlast.
    for (int j = 0; j < 4; j++) begin
      rd_d[j] = 32'h10 + j; rd_r[j] = 2'd0; rd_l[j] = (j == 3);
    end
    do_read(32'h2, 3);

    // Early rlast must not shorten the burst, but flags an error.
    rd_d[0] = 32'h1111_0000; rd_r[0] = 2'd0; rd_l[0] = 1'b1;
    rd_d[1] = 32'h1111_0001; rd_r[1] = 2'd0; rd_l[1] = 1'b0;
    do_read(32'h40, 1);

    // Stalled write with toggling source.
    for (int j = 0; j < 4; j++) wq[j] = 32'hC0DE_0000 + j;
    do_write(32'h80, 3, 2'd1, 1);

    // Worst response wins.
    for (int j = 0; j < 8; j++) begin
      rd_d[j] = $urandom; rd_r[j] = (j == 2) ? 2'd2 : 2'd0; rd_l[j] = (j == 7);
    end
    do_read(32'h100, 7);

    // Randomized mix.
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 15);
      if ($urandom % 2 == 0) begin
        for (int j = 0; j <= len; j++) wq[j] = $urandom;
        do_write($urandom, len, 2'($urandom), 0);
      end else begin
        for (int j = 0; j <= len; j++) begin
          rd_d[j] = $urandom;
          rd_r[j] = 2'($urandom);
          rd_l[j] = (j == len) ^ ($urandom % 8 == 0);
        end
        do_read($urandom, len);
      end
    end

    // Maximum length bursts.
    for (int j = 0; j < 256; j++) wq[j] = $urandom;
    do_write(32'hFFFF_0000, 255, 2'd3, 0);
    for (int j = 0; j < 256; j++) begin
      rd_d[j] = $urandom; rd_r[j] = 2'($urandom_range(0, 1)); rd_l[j] = (j == 255);
    end
    do_read(32'h0000_1000, 255);

    // Reset in the middle of the 3rd beat of an 8-beat write.
    for (int j = 0; j < 8; j++) wq[j] = 32'hDEAD_0000 + j;
    issue_cmd(1'b1, 32'h200, 7);
    @(negedge aclk);
    cmd_valid = 1'b0; awready = 1'b1;
    #1;
    chk("mid_awvalid", awvalid, 1);
    for (int b = 0; b < 2; b++) begin
      @(negedge aclk);
      wd_valid = 1'b1; wready = 1'b1; wd_data = wq[b];
      #1;
      chk("mid_wvalid", wvalid, 1);
      chk("mid_wlast",  wlast, 0);
    end
    @(negedge aclk);
    wd_valid = 1'b1; wready = 1'b1; wd_data = wq[2];
    rvalid = 1'b1; bvalid = 1'b1; arready = 1'b1; awready = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("mid_beat3_wvalid", wvalid, 1);
    #1 areset_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (2) begin
      @(negedge aclk);
      #1;
      chk("mid_rst_done", done, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
    end
    @(negedge aclk);
    areset_n = 1'b1; cmd_valid = 1'b0; wd_valid = 1'b0; wready = 1'b0;
    rvalid = 1'b0; bvalid = 1'b0; awready = 1'b0; arready = 1'b0;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_done", done, 0);
    repeat (3) begin
      @(negedge aclk);
      #1;
      chk("rel_idle_done",    done, 0);
      chk("rel_idle_awvalid", awvalid, 0);
      chk("rel_idle_cmd_ready", cmd_ready, 1);
    end

    // The block still works after an abandoned burst.
    wq[0] = 32'h1234_5678; wq[1] = 32'h9ABC_DEF0;
    do_write(32'h300, 1, 2'd2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
